wb_lsu_master: RTL



---
 rtl/wb_lsu_master.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_lsu_master.sv
// wb_lsu_master: turns one CPU load/store request into a single Wishbone classic cycle
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_*                 CPU request (valid/ready handshake, we, size, signed, addr, wdata)
//   rsp_*                 one-cycle response pulse with extended load data and error flag
//   cyc_o..dat_o          Wishbone master outputs, all registered
//   dat_i, ack_i, err_i,
//   rty_i                 Wishbone slave read data and terminations
module wb_lsu_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic        rty_i
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, ACTIVE, RETRY, RESP} state_t;
   state_t      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] a_addr_q, a_addr_d, a_dat_q, a_dat_d;
   logic        a_we_q, a_we_d, a_sgn_q, a_sgn_d;
   logic [1:0]  a_size_q, a_size_d;
   logic [3:0]  a_sel_q, a_sel_d;
   logic        ready_q, ready_d, valid_q, valid_d, err_q, err_d, cyc_q, cyc_d, we_q, we_d;
   logic [31:0] rdata_q, rdata_d, adr_q, adr_d, dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        accept, bad, idle_term, timeout;
   logic [31:0] lane, ext;
   assign accept    = state_q == IDLE && req_valid_i;
   assign bad       = req_size_i == 2'b11 || (req_size_i == 2'b01 && req_addr_i[0])
                   || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
   // no termination this cycle; the counter only advances on silent bus cycles
   assign idle_term = state_q == ACTIVE && !err_i && !ack_i && !rty_i;
   assign timeout   = idle_term && cnt_q >= CW'(TIMEOUT_CYCLES - 1);
   assign lane      = dat_i >> {a_addr_q[1:0], 3'b000};
   assign ext       = a_size_q == 2'b00 ? {{24{a_sgn_q & lane[7]}}, lane[7:0]}
                    : a_size_q == 2'b01 ? {{16{a_sgn_q & lane[15]}}, lane[15:0]} : lane;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_addr_q <= '0;
         a_dat_q  <= '0;
         a_we_q   <= 1'b0;
         a_sgn_q  <= 1'b0;
         a_size_q <= '0;
         a_sel_q  <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         sel_q    <= '0;
         dat_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_addr_q <= a_addr_d;
         a_dat_q  <= a_dat_d;
         a_we_q   <= a_we_d;
         a_sgn_q  <= a_sgn_d;
         a_size_q <= a_size_d;
         a_sel_q  <= a_sel_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         sel_q    <= sel_d;
         dat_q    <= dat_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? (bad ? RESP : ACTIVE) : IDLE;
         ACTIVE:  state_d = (err_i || ack_i || timeout) ? RESP : rty_i ? RETRY : ACTIVE;
         RETRY:   state_d = ACTIVE;
         default: state_d = IDLE;
      endcase
      // saturating counter, cleared only at accept so it spans retries
      cnt_d    = accept ? '0 : (idle_term && cnt_q != CW'(TIMEOUT_CYCLES)) ? cnt_q + 1'b1 : cnt_q;
      a_addr_d = accept ? req_addr_i : a_addr_q;
      a_we_d   = accept ? req_we_i : a_we_q;
      a_sgn_d  = accept ? req_signed_i : a_sgn_q;
      a_size_d = accept ? req_size_i : a_size_q;
      a_sel_d  = !accept ? a_sel_q : req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0]
               : req_size_i == 2'b01 ? 4'b0011 << req_addr_i[1:0] : 4'b1111;
      a_dat_d  = !accept ? a_dat_q : !req_we_i ? 32'h0
               : req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}}
               : req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
   end
   always_comb begin
      ready_d = state_d == IDLE;
      valid_d = state_d == RESP;
      cyc_d   = state_d == ACTIVE;
      err_d   = (accept && bad) || (state_q == ACTIVE && (err_i || (!ack_i && timeout)));
      rdata_d = (state_q == ACTIVE && !err_i && ack_i && !a_we_q) ? ext : 32'h0;
      we_d    = cyc_d && a_we_d;
      adr_d   = cyc_d ? {a_addr_d[31:2], 2'b00} : 32'h0;
      sel_d   = cyc_d ? a_sel_d : 4'h0;
      dat_d   = cyc_d ? a_dat_d : 32'h0;
   end
   assign req_ready_o = ready_q;
   assign rsp_valid_o = valid_q;
   assign rsp_err_o   = err_q;
   assign rsp_rdata_o = rdata_q;
   assign cyc_o       = cyc_q;
   assign stb_o       = cyc_q;
   assign we_o        = we_q;
   assign adr_o       = adr_q;
   assign sel_o       = sel_q;
   assign dat_o       = dat_q;
endmodule
